// File: rtl/jcounter_param.sv
// jcounter_param: parametrised Johnson (twisted-ring) counter with enable,
// up/down stepping, raw parallel load, illegal-state self-correction,
// binary phase decode and a registered wrap pulse.
module jcounter_param #(
  parameter int WIDTH = 4,
  parameter int PW    = $clog2(2 * WIDTH)
) (
  input  logic             in_clk,
  input  logic             in_clr_n,
  input  logic             in_en,
  input  logic             in_dir,
  input  logic             in_load,
  input  logic [WIDTH-1:0] in_load_val,
  output logic [WIDTH-1:0] o_q,
  output logic [PW-1:0]    o_phase,
  output logic             o_wrap,
  output logic             o_illegal
);

  localparam int SEQ_LEN = 2 * WIDTH;

  logic [WIDTH-1:0] q_next;
  logic             wrap_next;

  // Legal ring pattern for phase k: phases 0..W fill ones in from the top
  // bit downwards, phases W+1..2W-1 drain them back out from the top.
  function automatic logic [WIDTH-1:0] phase_pattern(input int k);
    logic [WIDTH-1:0] p;
    p = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (k <= WIDTH) begin
        p[i] = (i >= WIDTH - k);
      end else begin
        p[i] = (i <= SEQ_LEN - 1 - k);
      end
    end
    return p;
  endfunction

  // Decode the ring into a phase index; anything matching no phase is illegal
  // and reports phase 0.
  always_comb begin
    o_illegal = 1'b1;
    o_phase   = '0;
    for (int k = 0; k < SEQ_LEN; k++) begin
      if (o_q == phase_pattern(k)) begin
        o_illegal = 1'b0;
        o_phase   = PW'(k);
      end
    end
  end

  // Next-state selection: load beats correction, correction beats stepping.
  // The wrap flag only comes from a genuine step across the phase 0 boundary.
  always_comb begin
    q_next    = o_q;
    wrap_next = 1'b0;
    if (in_load) begin
      q_next = in_load_val;
    end else if (o_illegal) begin
      q_next = '0;
    end else if (in_en) begin
      if (in_dir) begin
        q_next    = {~o_q[0], o_q[WIDTH-1:1]};
        wrap_next = (o_phase == PW'(SEQ_LEN - 1));
      end else begin
        q_next    = {o_q[WIDTH-2:0], ~o_q[WIDTH-1]};
        wrap_next = (o_phase == '0);
      end
    end
  end

  // Ring and wrap registers; the active-low clear overrides everything.
  always_ff @(posedge in_clk) begin
    if (!in_clr_n) begin
      o_q    <= '0;
      o_wrap <= 1'b0;
    end else begin
      o_q    <= q_next;
      o_wrap <= wrap_next;
    end
  end

endmodule

// File: tb/tb_jcounter_param.sv
// tb_jcounter_param: directed-vector bench for jcounter_param at WIDTH 4,
// with WIDTH 2 and WIDTH 7 instances sharing the control inputs.
module tb_jcounter_param;

  logic       clk;
  logic       clr_n;
  logic       en;
  logic       dir;
  logic       load;
  logic [3:0] load_val4;
  logic [1:0] load_val2;
  logic [6:0] load_val7;

  logic [3:0] q4;
  logic [2:0] phase4;
  logic       wrap4;
  logic       illegal4;
  logic [1:0] q2;
  logic [1:0] phase2;
  logic       wrap2;
  logic       illegal2;
  logic [6:0] q7;
  logic [3:0] phase7;
  logic       wrap7;
  logic       illegal7;

  int checks;
  int failures;

  jcounter_param #(.WIDTH(4)) dut4 (
    .in_clk(clk), .in_clr_n(clr_n), .in_en(en), .in_dir(dir), .in_load(load),
    .in_load_val(load_val4), .o_q(q4), .o_phase(phase4), .o_wrap(wrap4),
    .o_illegal(illegal4)
  );

  jcounter_param #(.WIDTH(2)) dut2 (
    .in_clk(clk), .in_clr_n(clr_n), .in_en(en), .in_dir(dir), .in_load(load),
    .in_load_val(load_val2), .o_q(q2), .o_phase(phase2), .o_wrap(wrap2),
    .o_illegal(illegal2)
  );

  jcounter_param #(.WIDTH(7)) dut7 (
    .in_clk(clk), .in_clr_n(clr_n), .in_en(en), .in_dir(dir), .in_load(load),
    .in_load_val(load_val7), .o_q(q7), .o_phase(phase7), .o_wrap(wrap7),
    .o_illegal(illegal7)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected ring value for a phase, built arithmetically from run lengths.
  function automatic logic [6:0] exp7(input int k);
    if (k <= 7) return 7'(((1 << k) - 1) << (7 - k));
    else return 7'((1 << (14 - k)) - 1);
  endfunction

  function automatic logic [1:0] exp2(input int k);
    if (k <= 2) return 2'(((1 << k) - 1) << (2 - k));
    else return 2'((1 << (4 - k)) - 1);
  endfunction

  // Reset state of all instances.
  task automatic test_reset();
    clr_n = 1'b0; en = 1'b0; dir = 1'b1; load = 1'b0;
    load_val4 = '0; load_val2 = '0; load_val7 = '0;
    tick();
    tick();
    checks++;
    if (q4 !== 4'b0000) begin failures++; $display("[TB] FAIL reset_q4: got %b expected 0000", q4); end
    checks++;
    if (phase4 !== 3'd0) begin failures++; $display("[TB] FAIL reset_phase4: got %0d expected 0", phase4); end
    checks++;
    if (wrap4 !== 1'b0) begin failures++; $display("[TB] FAIL reset_wrap4: got %b expected 0", wrap4); end
    checks++;
    if (illegal4 !== 1'b0) begin failures++; $display("[TB] FAIL reset_illegal4: got %b expected 0", illegal4); end
    checks++;
    if (q2 !== 2'b00 || q7 !== 7'b0) begin failures++; $display("[TB] FAIL reset_q2_q7: got %b %b expected 00 0000000", q2, q7); end
    clr_n = 1'b1;
  endtask

  // Full forward sequence from phase 0 with a single wrap at 7 -> 0.
  task automatic test_up();
    logic [3:0] seq [8];
    seq = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000};
    en = 1'b1; dir = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (q4 !== seq[i]) begin failures++; $display("[TB] FAIL up_q step %0d: got %b expected %b", i, q4, seq[i]); end
      checks++;
      if (phase4 !== 3'(i + 1)) begin failures++; $display("[TB] FAIL up_phase step %0d: got %0d expected %0d", i, phase4, 3'(i + 1)); end
      checks++;
      if (wrap4 !== (i == 7)) begin failures++; $display("[TB] FAIL up_wrap step %0d: got %b expected %b", i, wrap4, (i == 7)); end
    end
  endtask

  // Reverse stepping from phase 0 wraps immediately to phase 7.
  task automatic test_down();
    logic [3:0] seq [3];
    logic [2:0] ph [3];
    seq = '{4'b0001, 4'b0011, 4'b0111};
    ph  = '{3'd7, 3'd6, 3'd5};
    dir = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (q4 !== seq[i]) begin failures++; $display("[TB] FAIL down_q step %0d: got %b expected %b", i, q4, seq[i]); end
      checks++;
      if (phase4 !== ph[i]) begin failures++; $display("[TB] FAIL down_phase step %0d: got %0d expected %0d", i, phase4, ph[i]); end
      checks++;
      if (wrap4 !== (i == 0)) begin failures++; $display("[TB] FAIL down_wrap step %0d: got %b expected %b", i, wrap4, (i == 0)); end
    end
  endtask

  // Hold at 1110, then reverse direction every cycle.
  task automatic test_hold_and_flip();
    logic [3:0] seq [4];
    seq = '{4'b1111, 4'b1110, 4'b1111, 4'b1110};
    tick();
    tick();
    checks++;
    if (q4 !== 4'b1110 || phase4 !== 3'd3) begin failures++; $display("[TB] FAIL hold_setup: got %b/%0d expected 1110/3", q4, phase4); end
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (q4 !== 4'b1110 || wrap4 !== 1'b0) begin failures++; $display("[TB] FAIL hold cycle %0d: got q=%b wrap=%b expected q=1110 wrap=0", i, q4, wrap4); end
    end
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dir = (i % 2 == 0);
      tick();
      checks++;
      if (q4 !== seq[i]) begin failures++; $display("[TB] FAIL flip_q step %0d: got %b expected %b", i, q4, seq[i]); end
    end
  endtask

  // Illegal load is corrected to phase 0 on the next edge without stepping.
  task automatic test_load_illegal();
    en = 1'b1; dir = 1'b1; load = 1'b1; load_val4 = 4'b1010;
    tick();
    checks++;
    if (q4 !== 4'b1010) begin failures++; $display("[TB] FAIL load_q: got %b expected 1010", q4); end
    checks++;
    if (illegal4 !== 1'b1 || phase4 !== 3'd0) begin failures++; $display("[TB] FAIL load_illegal: got ill=%b phase=%0d expected ill=1 phase=0", illegal4, phase4); end
    load = 1'b0;
    tick();
    checks++;
    if (q4 !== 4'b0000 || illegal4 !== 1'b0) begin failures++; $display("[TB] FAIL correct_q: got %b ill=%b expected 0000 ill=0", q4, illegal4); end
    checks++;
    if (wrap4 !== 1'b0) begin failures++; $display("[TB] FAIL correct_wrap: got %b expected 0", wrap4); end
    load = 1'b1; load_val4 = 4'b0111;
    tick();
    checks++;
    if (q4 !== 4'b0111 || phase4 !== 3'd5 || illegal4 !== 1'b0) begin failures++; $display("[TB] FAIL load_legal: got %b phase=%0d ill=%b expected 0111 phase=5 ill=0", q4, phase4, illegal4); end
  endtask

  // A load on the cycle an illegal value is showing wins over correction.
  task automatic test_load_while_illegal();
    load = 1'b1; load_val4 = 4'b0110;
    tick();
    checks++;
    if (illegal4 !== 1'b1) begin failures++; $display("[TB] FAIL lwi_illegal: got %b expected 1", illegal4); end
    load_val4 = 4'b0011;
    tick();
    checks++;
    if (q4 !== 4'b0011 || phase4 !== 3'd6) begin failures++; $display("[TB] FAIL lwi_q: got %b phase=%0d expected 0011 phase=6", q4, phase4); end
    load = 1'b0;
  endtask

  // Clear beats load and enable at phase 7, then counting resumes from 0.
  task automatic test_clear_priority();
    en = 1'b1; dir = 1'b1;
    tick();
    checks++;
    if (q4 !== 4'b0001 || phase4 !== 3'd7) begin failures++; $display("[TB] FAIL clr_setup: got %b phase=%0d expected 0001 phase=7", q4, phase4); end
    clr_n = 1'b0; load = 1'b1; load_val4 = 4'b0111;
    tick();
    checks++;
    if (q4 !== 4'b0000 || wrap4 !== 1'b0 || phase4 !== 3'd0) begin failures++; $display("[TB] FAIL clr_q: got %b wrap=%b phase=%0d expected 0000 wrap=0 phase=0", q4, wrap4, phase4); end
    clr_n = 1'b1; load = 1'b0;
    tick();
    checks++;
    if (q4 !== 4'b1000 || phase4 !== 3'd1 || wrap4 !== 1'b0) begin failures++; $display("[TB] FAIL clr_resume: got %b phase=%0d wrap=%b expected 1000 phase=1 wrap=0", q4, phase4, wrap4); end
  endtask

  // WIDTH 2 and 7: full sequences, wrap spacing, then clear at last phase.
  task automatic test_widths();
    int k2;
    int k7;
    clr_n = 1'b0; load = 1'b0;
    tick();
    clr_n = 1'b1; en = 1'b1; dir = 1'b1;
    for (int i = 0; i < 27; i++) begin
      tick();
      k2 = (i + 1) % 4;
      k7 = (i + 1) % 14;
      checks++;
      if (q7 !== exp7(k7) || phase7 !== 4'(k7)) begin failures++; $display("[TB] FAIL w7_step %0d: got %b phase=%0d expected %b phase=%0d", i, q7, phase7, exp7(k7), k7); end
      checks++;
      if (wrap7 !== (k7 == 0)) begin failures++; $display("[TB] FAIL w7_wrap step %0d: got %b expected %b", i, wrap7, (k7 == 0)); end
      checks++;
      if (q2 !== exp2(k2) || phase2 !== 2'(k2)) begin failures++; $display("[TB] FAIL w2_step %0d: got %b phase=%0d expected %b phase=%0d", i, q2, phase2, exp2(k2), k2); end
      checks++;
      if (wrap2 !== (k2 == 0)) begin failures++; $display("[TB] FAIL w2_wrap step %0d: got %b expected %b", i, wrap2, (k2 == 0)); end
    end
    clr_n = 1'b0; load = 1'b1; load_val2 = 2'b11; load_val7 = 7'b1111111;
    tick();
    checks++;
    if (q2 !== 2'b00 || wrap2 !== 1'b0) begin failures++; $display("[TB] FAIL w2_clr: got %b wrap=%b expected 00 wrap=0", q2, wrap2); end
    checks++;
    if (q7 !== 7'b0 || wrap7 !== 1'b0) begin failures++; $display("[TB] FAIL w7_clr: got %b wrap=%b expected 0000000 wrap=0", q7, wrap7); end
    clr_n = 1'b1; load = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_up();
    test_down();
    test_hold_and_flip();
    test_load_illegal();
    test_load_while_illegal();
    test_clear_priority();
    test_widths();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
